multiword_add_seq: RTL and testbench

Multi-cycle wide-operand adder/subtractor. It adds or subtracts two N×W-bit operands by passing them one W-bit slice per cycle through a single shared `carry_lookahead_adder` instance, chaining the carry between cycles. It sits between an operand producer and a result consumer, each with its own valid/ready handshake. It serves CNN accumulation paths where a full-width CLA is too large.

---
 rtl/multiword_add_seq.sv | 186 ++++++++++++++++++
 tb/tb_multiword_add_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Adds or subtracts two N*W-bit unsigned operands one W-bit slice per cycle.
//   A single shared carry_lookahead_adder is used, and the carry is chained
//   between cycles through a register.
//
//   Ports
//     i_clk, i_rst_n      clock, asynchronous active-low reset
//     i_valid / o_ready   operand request handshake (i_op_a, i_op_b, i_sub)
//     o_valid / i_ready   result handshake (o_result)
//     o_result[N*W-1:0]   sum or difference
//     o_result[N*W]       final carry-out (inverted borrow when subtracting)
//     o_busy              high whenever the block is not idle
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; o_result holds the previous result
//   RUN   | processing slice idx (LSB slice first), one slice per cycle
//   DONE  | result valid and held until the consumer takes it

module carry_lookahead_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_add1,
  input  logic [W-1:0] i_add2,
  output logic [W:0]   o_result
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;
  logic         prop_run;

  // Each carry is formed directly from the generate/propagate terms of all
  // lower bits rather than from the previous carry.
  always_comb begin
    gen      = i_add1 & i_add2;
    prop     = i_add1 ^ i_add2;
    carry    = '0;
    prop_run = 1'b1;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gen[i];
      prop_run   = 1'b1;
      for (int j = i; j > 0; j--) begin
        prop_run   = prop_run & prop[j];
        carry[i+1] = carry[i+1] | (gen[j-1] & prop_run);
      end
    end
    o_result = {carry[W], prop ^ carry[W-1:0]};
  end

endmodule

module multiword_add_seq #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N*W-1:0] i_op_a,
  input  logic [N*W-1:0] i_op_b,
  input  logic           i_sub,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [N*W:0]   o_result,
  output logic           o_busy
);

  localparam int M  = N * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [M:0]      result_q, result_d;

  logic [W-1:0]    b_slice_eff;
  logic [W:0]      cla_add1;
  logic [W:0]      cla_add2;
  logic [W+1:0]    cla_sum;
  logic [W-1:0]    slice_sum;
  logic            slice_cout;
  logic            cla_lsb_unused;

  // Captured operands shift right by one slice per RUN cycle, so the current
  // slice is always the low W bits.
  assign b_slice_eff = sub_q ? ~b_q[W-1:0] : b_q[W-1:0];

  // The extra LSB position injects carry_q: 1 + carry_q produces a carry of
  // exactly carry_q into bit 1, and its own sum bit is meaningless.
  assign cla_add1 = {a_q[W-1:0], 1'b1};
  assign cla_add2 = {b_slice_eff, carry_q};

  carry_lookahead_adder #(.W(W + 1)) u_cla (
    .i_add1   (cla_add1),
    .i_add2   (cla_add2),
    .o_result (cla_sum)
  );

  assign slice_sum      = cla_sum[W:1];
  assign slice_cout     = cla_sum[W+1];
  assign cla_lsb_unused = cla_sum[0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_op_a;
          b_d     = i_op_b;
          sub_d   = i_sub;
          carry_d = i_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d[idx_q*W +: W] = slice_sum;
        carry_d                = slice_cout;
        a_d                    = a_q >> W;
        b_d                    = b_q >> W;
        if (idx_q == IW'(N - 1)) begin
          result_d[M] = slice_cout;
          idx_d       = '0;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_result = result_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Testbench for multiword_add_seq: directed vectors on a W=8/N=4 instance,
// plus continuous back-to-back traffic on W=3/N=1 and W=1/N=5 instances.
// Expected results are queued at issue time and popped by a monitor on each
// result handshake.

module tb_multiword_add_seq;

  localparam int W0 = 8, N0 = 4, M0 = 32;
  localparam int W1 = 3, N1 = 1, M1 = 3;
  localparam int W2 = 1, N2 = 5, M2 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0_n, rst_s_n;

  logic          v0, rdy0, s0, ov0, ir0, busy0;
  logic [M0-1:0] a0, b0;
  logic [M0:0]   res0;

  logic          v1, rdy1, s1, ov1, ir1, busy1;
  logic [M1-1:0] a1, b1;
  logic [M1:0]   res1;

  logic          v2, rdy2, s2, ov2, ir2, busy2;
  logic [M2-1:0] a2, b2;
  logic [M2:0]   res2;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  int n_cmp = 0;
  int n_bad = 0;

  multiword_add_seq #(.W(W0), .N(N0)) u0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_valid(v0), .o_ready(rdy0),
    .i_op_a(a0), .i_op_b(b0), .i_sub(s0), .o_valid(ov0), .i_ready(ir0),
    .o_result(res0), .o_busy(busy0)
  );

  multiword_add_seq #(.W(W1), .N(N1)) u1 (
    .i_clk(clk), .i_rst_n(rst_s_n), .i_valid(v1), .o_ready(rdy1),
    .i_op_a(a1), .i_op_b(b1), .i_sub(s1), .o_valid(ov1), .i_ready(ir1),
    .o_result(res1), .o_busy(busy1)
  );

  multiword_add_seq #(.W(W2), .N(N2)) u2 (
    .i_clk(clk), .i_rst_n(rst_s_n), .i_valid(v2), .o_ready(rdy2),
    .i_op_a(a2), .i_op_b(b2), .i_sub(s2), .o_valid(ov2), .i_ready(ir2),
    .o_result(res2), .o_busy(busy2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: add is the plain M+1-bit sum; subtract is the modular
  // difference with the top bit set when no borrow occurs (A >= B).
  function automatic logic [63:0] ref_calc(input logic [63:0] a, input logic [63:0] b,
                                           input logic sub, input int m);
    logic [63:0] mask;
    mask = (64'd1 << m) - 64'd1;
    if (!sub) return a + b;
    return ((a - b) & mask) | ((a >= b) ? (64'd1 << m) : 64'd0);
  endfunction

  // Monitor: one pop per result handshake on each instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst0_n && ov0 && ir0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result0: got 0x%0h, required no result", res0);
        end else begin
          chk("result0", 64'(res0), q0.pop_front());
          chk("busy0_done", 64'(busy0), 64'd1);
        end
      end
      if (rst_s_n && ov1 && ir1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result1: got 0x%0h, required no result", res1);
        end else begin
          chk("result1", 64'(res1), q1.pop_front());
          chk("busy1_done", 64'(busy1), 64'd1);
        end
      end
      if (rst_s_n && ov2 && ir2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result2: got 0x%0h, required no result", res2);
        end else begin
          chk("result2", 64'(res2), q2.pop_front());
          chk("busy2_done", 64'(busy2), 64'd1);
        end
      end
    end
  end

  // Issue one request on u0 and check o_valid rises exactly N0 edges after
  // the accept edge with o_busy high throughout. Returns at TN + 1.
  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] exp);
    int k;
    k = 0;
    while (!rdy0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy0) begin
      chk("ready0_timeout", 64'(rdy0), 64'd1);
      return;
    end
    a0 = a; b0 = b; s0 = s; v0 = 1'b1;
    q0.push_back(exp);
    @(posedge clk); #1;
    v0 = 1'b0;
    a0 = ~a; b0 = ~b; s0 = ~s;
    chk("busy0_accept", 64'(busy0), 64'd1);
    for (int c = 1; c <= N0; c++) begin
      @(posedge clk); #1;
      chk("valid0_latency", 64'(ov0), (c == N0) ? 64'd1 : 64'd0);
      chk("busy0_run", 64'(busy0), 64'd1);
    end
  endtask

  task automatic sweep1();
    int cyc, prev, cnt;
    logic r;
    logic [M1-1:0] a, b;
    logic s;
    cyc = 0; prev = -1; cnt = 0;
    a = M1'($urandom); b = M1'($urandom); s = 1'($urandom);
    a1 = a; b1 = b; s1 = s; v1 = 1'b1;
    while (cnt < 100 && cyc < 5000) begin
      @(negedge clk);
      r = rdy1;
      @(posedge clk);
      cyc++;
      if (r) begin
        q1.push_back(ref_calc(64'(a), 64'(b), s, M1));
        if (prev >= 0) chk("spacing1", 64'(cyc - prev), 64'(N1 + 2));
        prev = cyc;
        cnt++;
        #1;
        a = M1'($urandom); b = M1'($urandom); s = 1'($urandom);
        a1 = a; b1 = b; s1 = s;
      end
    end
    v1 = 1'b0;
    if (cnt < 100) chk("sweep1_accepts", 64'(cnt), 64'd100);
  endtask

  task automatic sweep2();
    int cyc, prev, cnt;
    logic r;
    logic [M2-1:0] a, b;
    logic s;
    cyc = 0; prev = -1; cnt = 0;
    a = M2'($urandom); b = M2'($urandom); s = 1'($urandom);
    a2 = a; b2 = b; s2 = s; v2 = 1'b1;
    while (cnt < 100 && cyc < 5000) begin
      @(negedge clk);
      r = rdy2;
      @(posedge clk);
      cyc++;
      if (r) begin
        q2.push_back(ref_calc(64'(a), 64'(b), s, M2));
        if (prev >= 0) chk("spacing2", 64'(cyc - prev), 64'(N2 + 2));
        prev = cyc;
        cnt++;
        #1;
        a = M2'($urandom); b = M2'($urandom); s = 1'($urandom);
        a2 = a; b2 = b; s2 = s;
      end
    end
    v2 = 1'b0;
    if (cnt < 100) chk("sweep2_accepts", 64'(cnt), 64'd100);
  endtask

  initial begin
    int k;
    rst0_n = 1'b0; rst_s_n = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; s0 = 1'b0; ir0 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; ir1 = 1'b1;
    v2 = 1'b0; a2 = '0; b2 = '0; s2 = 1'b0; ir2 = 1'b1;

    #1;
    chk("reset_ready0", 64'(rdy0), 64'd1);
    chk("reset_valid0", 64'(ov0), 64'd0);
    chk("reset_busy0", 64'(busy0), 64'd0);
    chk("reset_result0", 64'(res0), 64'd0);

    @(negedge clk); @(negedge clk);
    rst0_n = 1'b1; rst_s_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the 8x4 instance.
    op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h1_0000_0000);
    op0(32'h0000_0005, 32'h0000_0007, 1'b1, 64'h0_FFFF_FFFE);
    op0(32'h0000_0007, 32'h0000_0005, 1'b1, 64'h1_0000_0002);
    op0(32'hABCD_1234, 32'hABCD_1234, 1'b1, 64'h1_0000_0000);
    op0(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h1_0000_0000);
    op0(32'h00FF_00FF, 32'h0001_0001, 1'b0, 64'h0_0100_0100);

    // Backpressure: result and o_ready held through 10 stalled cycles, and a
    // request pulse during DONE is ignored.
    @(posedge clk); #1;
    ir0 = 1'b0;
    op0(32'h1234_5678, 32'h1111_1111, 1'b0, 64'h0_2345_6789);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result0", 64'(res0), 64'h0_2345_6789);
      chk("bp_ready0", 64'(rdy0), 64'd0);
      chk("bp_valid0", 64'(ov0), 64'd1);
      if (i == 3) begin
        a0 = 32'hDEAD_BEEF; b0 = 32'h0BAD_F00D; s0 = 1'b1; v0 = 1'b1;
      end
      if (i == 4) v0 = 1'b0;
      @(posedge clk); #1;
    end
    ir0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready0", 64'(rdy0), 64'd1);
    chk("bp_release_valid0", 64'(ov0), 64'd0);

    // Reset while RUN is on slice 2; the in-flight request must vanish.
    a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; s0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy0", 64'(busy0), 64'd1);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("midrst_ready0", 64'(rdy0), 64'd1);
    chk("midrst_busy0", 64'(busy0), 64'd0);
    chk("midrst_valid0", 64'(ov0), 64'd0);
    chk("midrst_result0", 64'(res0), 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_valid0", 64'(ov0), 64'd0);
    end
    op0(32'h0000_0001, 32'h0000_0001, 1'b0, 64'h0_0000_0002);

    // Back-to-back traffic on the other two parameterisations.
    fork
      sweep1();
      sweep2();
    join

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (q0.size() != 0) chk("drain_q0", 64'(q0.size()), 64'd0);
    if (q1.size() != 0) chk("drain_q1", 64'(q1.size()), 64'd0);
    if (q2.size() != 0) chk("drain_q2", 64'(q2.size()), 64'd0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
